// File: rtl/dm_sba_axi_bridge.sv
// Bridges the debug module system-bus-access port (req/gnt/r_valid) onto single-beat AXI4
// transactions, one outstanding at a time, with a sticky error flag for the debugger.
module dm_sba_axi_bridge #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    r_valid_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o,
    output logic                    r_err_o,
    output logic                    err_sticky_o,
    input  logic                    err_clr_i,
    output logic                    busy_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [ID_WIDTH-1:0]     aw_id_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic                    w_valid_o,
    input  logic                    w_ready_i,
    output logic [DATA_WIDTH-1:0]   w_data_o,
    output logic [DATA_WIDTH/8-1:0] w_strb_o,
    output logic                    w_last_o,
    input  logic                    b_valid_i,
    output logic                    b_ready_o,
    input  logic [1:0]              b_resp_i,
    input  logic [ID_WIDTH-1:0]     b_id_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [ID_WIDTH-1:0]     ar_id_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]              r_resp_i,
    input  logic [ID_WIDTH-1:0]     r_id_i,
    input  logic                    r_last_i
);
    localparam logic [2:0] AXI_SIZE = (DATA_WIDTH == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_B, S_AR, S_R} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] be_q, be_d;
    logic                    aw_valid_q, aw_valid_d;
    logic                    w_valid_q, w_valid_d;
    logic                    ar_valid_q, ar_valid_d;
    logic                    r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    r_err_q, r_err_d;
    logic                    err_sticky_q, err_sticky_d;

    // Single-beat transfers with a fixed ID: response IDs and r_last carry no information.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{b_id_i, r_id_i, r_last_i};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        r_valid_d  = 1'b0;
        rdata_d    = rdata_q;
        r_err_d    = r_err_q;
        gnt_o      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i && !rst) begin
                    gnt_o   = 1'b1;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    be_d    = be_i;
                    if (we_i) begin
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        state_d    = S_WRITE;
                    end else begin
                        ar_valid_d = 1'b1;
                        state_d    = S_AR;
                    end
                end
            end
            S_WRITE: begin
                // AW and W complete independently; leave once neither is still pending.
                if (aw_ready_i) aw_valid_d = 1'b0;
                if (w_ready_i)  w_valid_d  = 1'b0;
                if ((!aw_valid_q || aw_ready_i) && (!w_valid_q || w_ready_i))
                    state_d = S_B;
            end
            S_B: begin
                if (b_valid_i) begin
                    r_valid_d = 1'b1;
                    rdata_d   = '0;
                    r_err_d   = b_resp_i[1];
                    state_d   = S_IDLE;
                end
            end
            S_AR: begin
                if (ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    state_d    = S_R;
                end
            end
            S_R: begin
                if (r_valid_i) begin
                    r_valid_d = 1'b1;
                    rdata_d   = r_data_i;
                    r_err_d   = r_resp_i[1];
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new error outranks a simultaneous clear so no error is ever lost.
        err_sticky_d = err_sticky_q;
        if (err_clr_i)              err_sticky_d = 1'b0;
        if (r_valid_d && r_err_d)   err_sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            r_valid_q    <= 1'b0;
            rdata_q      <= '0;
            r_err_q      <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            aw_valid_q   <= aw_valid_d;
            w_valid_q    <= w_valid_d;
            ar_valid_q   <= ar_valid_d;
            r_valid_q    <= r_valid_d;
            rdata_q      <= rdata_d;
            r_err_q      <= r_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign r_valid_o    = r_valid_q;
    assign r_rdata_o    = rdata_q;
    assign r_err_o      = r_err_q;
    assign err_sticky_o = err_sticky_q;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = ID_WIDTH'(AXI_ID);
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = AXI_SIZE;
    assign aw_burst_o = 2'b01;

    assign w_valid_o = w_valid_q;
    assign w_data_o  = wdata_q;
    assign w_strb_o  = be_q;
    assign w_last_o  = 1'b1;

    assign b_ready_o = (state_q == S_B);

    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = ID_WIDTH'(AXI_ID);
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = AXI_SIZE;
    assign ar_burst_o = 2'b01;

    assign r_ready_o = (state_q == S_R);
endmodule

// File: tb/tb_dm_sba_axi_bridge.sv
// Bench for dm_sba_axi_bridge: vector table of SBA transactions against a scripted AXI slave,
// with completions scored through an expected queue.
module tb_dm_sba_axi_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_i, gnt_o, we_i;
  logic [63:0] addr_i, wdata_i;
  logic [7:0]  be_i;
  logic        r_valid_o, r_err_o, err_sticky_o, err_clr_i, busy_o;
  logic [63:0] r_rdata_o;
  logic        aw_valid_o, aw_ready_i;
  logic [63:0] aw_addr_o;
  logic [3:0]  aw_id_o;
  logic [7:0]  aw_len_o;
  logic [2:0]  aw_size_o;
  logic [1:0]  aw_burst_o;
  logic        w_valid_o, w_ready_i, w_last_o;
  logic [63:0] w_data_o;
  logic [7:0]  w_strb_o;
  logic        b_valid_i, b_ready_o;
  logic [1:0]  b_resp_i;
  logic [3:0]  b_id_i;
  logic        ar_valid_o, ar_ready_i;
  logic [63:0] ar_addr_o;
  logic [3:0]  ar_id_o;
  logic [7:0]  ar_len_o;
  logic [2:0]  ar_size_o;
  logic [1:0]  ar_burst_o;
  logic        r_valid_i, r_ready_o, r_last_i;
  logic [63:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic [3:0]  r_id_i;

  dm_sba_axi_bridge dut (
    .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .be_i(be_i), .r_valid_o(r_valid_o), .r_rdata_o(r_rdata_o),
    .r_err_o(r_err_o), .err_sticky_o(err_sticky_o), .err_clr_i(err_clr_i), .busy_o(busy_o),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
    .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
    .w_last_o(w_last_o), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
    .b_id_i(b_id_i), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_id_o(ar_id_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
    .r_id_i(r_id_i), .r_last_i(r_last_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [63:0] rdata;
    logic        clr_hs;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  logic [64:0] exp_q[$];
  logic [64:0] exp_item;
  int  total = 0;
  int  bad = 0;
  bit  gnt_seen = 0;
  bit  rv_since = 0;
  bit  sticky_m = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: every completion pops one expectation pushed at grant time
  always @(negedge clk) begin
    if (r_valid_o) begin
      rv_since = 1'b1;
      if (exp_q.size() == 0) chk("unexpected_rvalid", 65'(r_valid_o), 65'd0);
      else begin
        exp_item = exp_q.pop_front();
        chk("completion", {r_err_o, r_rdata_o}, exp_item);
      end
    end
    if (gnt_o) begin
      chk("gnt_only_idle", 65'(busy_o), 65'd0);
      if (gnt_seen) chk("gnt_after_rvalid", 65'(rv_since), 65'd1);
      gnt_seen = 1'b1;
      rv_since = 1'b0;
    end
  end

  task automatic idle_inputs();
    req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0; be_i = '0; err_clr_i = 0;
    aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0; b_id_i = 0;
    ar_ready_i = 0; r_valid_i = 0; r_data_i = '0; r_resp_i = 0; r_id_i = 0; r_last_i = 1;
  endtask

  // driver: caller sits #1 after a posedge; returns in the same position
  task automatic run_txn(input vec_t v);
    bit granted = 0, done = 0, aw_d = 0, w_d = 0, ar_d = 0, rsp_d = 0, both, rsp_valid;
    int aw_n = 0, w_n = 0, ar_n = 0, rsp_n = 0, wcnt = 0, lat = -1, busy_bad = 0;
    req_i = 1; we_i = v.we; addr_i = v.addr; wdata_i = v.wdata; be_i = v.be;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (gnt_o) begin
        granted = 1;
        exp_q.push_back({v.exp_err, v.exp_rdata});
      end
      @(posedge clk); #1;
    end
    req_i = 0;
    chk("granted", 65'(granted), 65'd1);
    if (!granted) return;
    addr_i = {$urandom, $urandom}; wdata_i = {$urandom, $urandom}; be_i = 8'($urandom);
    for (int k = 0; k < 60 && !done; k++) begin
      aw_ready_i = v.we && (k >= v.aw_dly);
      w_ready_i  = v.we && (k >= v.w_dly);
      ar_ready_i = !v.we && (k >= v.ar_dly);
      both = v.we ? (aw_d && w_d) : ar_d;
      rsp_valid = both && !rsp_d && (wcnt >= (v.we ? v.b_dly : v.r_dly));
      b_valid_i = v.we && rsp_valid;   b_resp_i = v.resp;
      r_valid_i = !v.we && rsp_valid;  r_resp_i = v.resp;  r_data_i = v.rdata;
      err_clr_i = v.clr_hs && rsp_valid;
      @(negedge clk);
      if (aw_valid_o) begin
        chk("aw_addr", aw_addr_o, v.addr);
        chk("aw_ctrl", {aw_id_o, aw_len_o, aw_size_o, aw_burst_o}, {4'd0, 8'd0, 3'd3, 2'b01});
      end
      if (w_valid_o) chk("w_payload", {w_last_o, w_strb_o, w_data_o}, {1'b1, v.be, v.wdata});
      if (ar_valid_o) begin
        chk("ar_addr", ar_addr_o, v.addr);
        chk("ar_ctrl", {ar_id_o, ar_len_o, ar_size_o, ar_burst_o}, {4'd0, 8'd0, 3'd3, 2'b01});
      end
      if (aw_valid_o && aw_ready_i) begin aw_n++; aw_d = 1; end
      if (w_valid_o && w_ready_i) begin w_n++; w_d = 1; end
      if (ar_valid_o && ar_ready_i) begin ar_n++; ar_d = 1; end
      if ((b_valid_i && b_ready_o) || (r_valid_i && r_ready_o)) begin rsp_n++; rsp_d = 1; end
      if (both) wcnt++;
      if (r_valid_o) begin done = 1; lat = k; end
      else if (!busy_o) busy_bad++;
      @(posedge clk); #1;
    end
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0; err_clr_i = 0;
    chk("completed", 65'(done), 65'd1);
    chk("busy_while_active", 65'(busy_bad), 65'd0);
    chk("handshakes", {32'(aw_n), 32'(w_n + ar_n)}, v.we ? {32'd1, 32'd1} : {32'd0, 32'd1});
    chk("resp_handshakes", 65'(rsp_n), 65'd1);
    if (v.exp_lat >= 0) chk("latency", 65'(lat), 65'(v.exp_lat));
    if (v.exp_err) sticky_m = 1;
    else if (v.clr_hs) sticky_m = 0;
    @(negedge clk);
    chk("rvalid_single_pulse", 65'(r_valid_o), 65'd0);
    chk("rdata_hold", {r_err_o, r_rdata_o}, {v.exp_err, v.exp_rdata});
    chk("err_sticky", 65'(err_sticky_o), 65'(sticky_m));
    @(posedge clk); #1;
  endtask

  task automatic clear_alone();
    err_clr_i = 1;
    @(posedge clk); #1;
    err_clr_i = 0;
    sticky_m = 0;
    @(negedge clk);
    chk("clear_alone", 65'(err_sticky_o), 65'd0);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_r();
    bit granted = 0, in_r = 0;
    req_i = 1; we_i = 0; addr_i = 64'h5000_0000;
    for (int i = 0; i < 20 && !granted; i++) begin
      @(negedge clk);
      if (gnt_o) begin granted = 1; exp_q.push_back(65'd0); end
      @(posedge clk); #1;
    end
    req_i = 0;
    ar_ready_i = 1;
    for (int i = 0; i < 20 && !in_r; i++) begin
      @(negedge clk);
      if (r_ready_o) in_r = 1;
      else begin @(posedge clk); #1; end
    end
    ar_ready_i = 0;
    chk("reached_r", 65'(in_r), 65'd1);
    r_valid_i = 1; r_data_i = 64'hFFFF_0000_FFFF_0000; r_resp_i = 2'b11; rst = 1;
    @(posedge clk); #1;
    rst = 0; r_valid_i = 0;
    @(negedge clk);
    chk("reset_mid_state", {busy_o, r_ready_o, err_sticky_o, r_valid_o, r_err_o}, 65'd0);
    chk("reset_mid_rdata", r_rdata_o, 65'd0);
    exp_q.delete();
    gnt_seen = 0; rv_since = 0; sticky_m = 0;
    @(posedge clk); #1;
  endtask

  task automatic back_to_back();
    int grants = 0;
    bit drained = 0;
    req_i = 1; we_i = 0; addr_i = 64'h6000_0040; ar_ready_i = 1;
    r_data_i = 64'h0BAD_F00D_1234_5678; r_resp_i = 2'b00;
    for (int i = 0; i < 40 && grants < 3; i++) begin
      r_valid_i = r_ready_o;
      @(negedge clk);
      if (gnt_o) begin grants++; exp_q.push_back({1'b0, 64'h0BAD_F00D_1234_5678}); end
      @(posedge clk); #1;
    end
    req_i = 0;
    for (int i = 0; i < 20 && !drained; i++) begin
      r_valid_i = r_ready_o;
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_o) drained = 1;
      @(posedge clk); #1;
    end
    ar_ready_i = 0; r_valid_i = 0;
    chk("b2b_grants", 65'(grants), 65'd3);
    chk("b2b_drained", 65'(drained), 65'd1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 64'h1000_0008, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, 2};
    vecs[1] = '{1'b0, 64'h2000_0000, 64'h0, 8'h00, 0, 0, 0, 0, 5, 2'b00, 64'h0123456789ABCDEF, 1'b0, 64'h0123456789ABCDEF, 1'b0, -1};
    vecs[2] = '{1'b1, 64'h3000_0010, 64'h1111_2222_3333_4444, 8'h0F, 0, 4, 0, 0, 0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, -1};
    vecs[3] = '{1'b1, 64'h3000_0018, 64'h5555_6666_7777_8888, 8'hF0, 3, 0, 0, 0, 0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, -1};
    vecs[4] = '{1'b0, 64'h4000_0100, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 2};
    vecs[5] = '{1'b1, 64'h4000_0200, 64'h0102_0304_0506_0708, 8'h3C, 1, 1, 2, 0, 0, 2'b10, 64'h0, 1'b0, 64'h0, 1'b1, -1};
    vecs[6] = '{1'b0, 64'h7000_0000, 64'h0, 8'h00, 0, 0, 0, 2, 0, 2'b11, 64'h0000_0000_0000_BAD0, 1'b0, 64'h0000_0000_0000_BAD0, 1'b1, -1};
    vecs[7] = '{1'b0, 64'h7000_0008, 64'h0, 8'h00, 0, 0, 0, 0, 1, 2'b11, 64'h1234_0000_0000_0000, 1'b1, 64'h1234_0000_0000_0000, 1'b1, -1};
    vecs[8] = '{1'b0, 64'h8000_0020, 64'h0, 8'h00, 0, 0, 0, 3, 1, 2'b00, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFEDC_BA98_7654_3210, 1'b0, -1};
    vecs[9] = '{1'b1, 64'h8000_0028, 64'h9999_AAAA_BBBB_CCCC, 8'h81, 0, 0, 3, 0, 0, 2'b00, 64'h0, 1'b0, 64'h0, 1'b0, -1};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {gnt_o, r_valid_o, r_err_o, err_sticky_o, busy_o, aw_valid_o, w_valid_o,
                       b_ready_o, ar_valid_o, r_ready_o}, 65'd0);
    chk("reset_data", {r_rdata_o, 1'b0}, 65'd0);
    chk("reset_regs", {aw_addr_o, 1'b0}, 65'd0);
    chk("reset_wregs", {w_strb_o, w_data_o}, 65'd0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i <= 5; i++) run_txn(vecs[i]);
    clear_alone();
    for (int i = 6; i <= 7; i++) run_txn(vecs[i]);
    reset_in_r();
    for (int i = 8; i < NVEC; i++) run_txn(vecs[i]);
    back_to_back();

    for (int n = 0; n < 8; n++) begin
      vec_t v;
      v.we = 1'($urandom_range(0, 1));
      v.addr = {32'h0, $urandom} & ~64'h7;
      v.wdata = {$urandom, $urandom};
      v.be = 8'($urandom_range(1, 255));
      v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3);
      v.b_dly = $urandom_range(0, 3);  v.ar_dly = $urandom_range(0, 3);
      v.r_dly = $urandom_range(0, 3);
      v.resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
      v.rdata = {$urandom, $urandom};
      v.clr_hs = 1'b0;
      v.exp_rdata = v.we ? 64'h0 : v.rdata;
      v.exp_err = v.resp[1];
      v.exp_lat = -1;
      run_txn(v);
    end
    chk("scoreboard_empty", 65'(exp_q.size()), 65'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dm_sba_axi_bridge.md
Name: dm_sba_axi_bridge

Overview:
- Converts the debug module system-bus-access master port (req/gnt/r_valid memory protocol) into single-beat AXI4 transactions on an XLEN-wide bus.
- Sits directly downstream of the debug module master port and upstream of the XLEN-to-SoC AXI data-width converter.
- Only one transaction is outstanding at a time.
- Reports AXI error responses back to the debug module and keeps a sticky error flag.

Parameters:
ADDR_WIDTH, 64, AXI and request address width
DATA_WIDTH, 64, XLEN; AXI data width, 32 or 64 only
ID_WIDTH, 4, AXI ID width
AXI_ID, 0, constant ID driven on AW and AR

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_i  in  1  request from debug module
gnt_o  out  1  request accepted
addr_i  in  ADDR_WIDTH  byte address
we_i  in  1  1 = write, 0 = read
wdata_i  in  DATA_WIDTH  write data
be_i  in  DATA_WIDTH/8  byte enables
r_valid_o  out  1  completion pulse, reads and writes
r_rdata_o  out  DATA_WIDTH  read data; 0 for writes
r_err_o  out  1  completion carried SLVERR/DECERR
err_sticky_o  out  1  set on any error completion
err_clr_i  in  1  clears err_sticky_o
busy_o  out  1  FSM not IDLE
aw_valid_o/aw_ready_i, aw_addr_o[ADDR_WIDTH], aw_id_o[ID_WIDTH], aw_len_o[8], aw_size_o[3], aw_burst_o[2]  AXI AW
w_valid_o/w_ready_i, w_data_o[DATA_WIDTH], w_strb_o[DATA_WIDTH/8], w_last_o  AXI W
b_valid_i/b_ready_o, b_resp_i[2], b_id_i[ID_WIDTH]  AXI B
ar_valid_o/ar_ready_i, ar_addr_o, ar_id_o, ar_len_o, ar_size_o, ar_burst_o  AXI AR
r_valid_i/r_ready_o, r_data_i[DATA_WIDTH], r_resp_i[2], r_id_i, r_last_i  AXI R

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - FSM = IDLE.
  - All valid/ready outputs = 0; gnt_o = 0; r_valid_o = 0; r_err_o = 0; err_sticky_o = 0.
  - Address, data and strobe registers = 0.
- Constant AXI fields: len = 0, burst = INCR (2'b01), w_last_o = 1, size = 3 for DATA_WIDTH 64 and 2 for DATA_WIDTH 32. AW/AR IDs = AXI_ID.
- IDLE:
  - gnt_o is combinational: gnt_o = req_i && state==IDLE.
  - On gnt_o, register addr/wdata/be/we. Next state is WRITE if we_i, else AR.
  - Next-cycle aw_valid_o = w_valid_o = 1 for a write; ar_valid_o = 1 for a read.
- WRITE:
  - AW and W valids drop independently, each on its own handshake. Either order or the same cycle is legal.
  - Once both handshakes are done, go to B with b_ready_o = 1.
  - Valids never drop before their handshake; payloads stay stable while valid.
- B: on b_valid_i, pulse r_valid_o for one cycle with r_rdata_o = 0 and r_err_o = b_resp_i[1]. Return to IDLE.
- AR: hold ar_valid_o until ar_ready_i, then go to R with r_ready_o = 1.
- R: on r_valid_i, pulse r_valid_o with r_rdata_o = r_data_i and r_err_o = r_resp_i[1]. Return to IDLE.
- Back-to-back: gnt_o may assert in the cycle after r_valid_o. Minimum latency with zero-wait AXI:
  - write: gnt at cycle 0 -> r_valid_o at cycle 3;
  - read: gnt at cycle 0 -> r_valid_o at cycle 3.
- r_rdata_o and r_err_o are registered and hold until the next completion. r_valid_o is a single-cycle pulse.
- err_sticky_o:
  - Set in the cycle after an error completion.
  - err_clr_i clears it; if a set and a clear coincide, set wins.
- busy_o = (state != IDLE).
- req_i while busy: ignored, no gnt_o. The debug module holds req until granted.
- Mid-transaction reset: every state and output returns to its reset value the next cycle. The interconnect is reset by the same rst.

Test Plan:
- Write 0x1000_0008, wdata 0xDEADBEEF_CAFEF00D, be 0xFF, zero-wait slave -> AW addr 0x10000008, size 3, len 0; W strb 0xFF, last 1; r_valid_o at cycle 3; r_err_o = 0.
- Read 0x2000_0000, slave returns 0x0123456789ABCDEF OKAY after 5 wait cycles on R -> single r_valid_o pulse with r_rdata_o = 0x0123456789ABCDEF; busy_o high throughout.
- Write with w_ready_i delayed 4 cycles after aw_ready_i, then with AW delayed after W -> exactly one B wait; AW and W each handshake exactly once; payload stable while waiting.
- Read returning DECERR (2'b11) -> r_err_o = 1 and err_sticky_o = 1; assert err_clr_i together with a second error completion -> err_sticky_o stays 1; clear alone -> 0.
- req_i held high through 3 back-to-back reads -> gnt_o only in IDLE; never two gnt_o pulses without an intervening r_valid_o.
- Assert rst while in R with r_valid_i pending -> next cycle state IDLE, r_ready_o = 0, err_sticky_o = 0, no r_valid_o pulse.
